// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing defaults, the frame-length and
// counter-width helpers, and the RGB pixel struct.
package vga_pkg;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_PULSE  = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_PIXELS = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_PULSE  = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLOR_W  = 4;

    // One pixel at the default channel depth, red in the top bits.
    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    // Total clocks (or lines) of one line (or frame) including blanking.
    function automatic int frame_len(input int pixels, input int fp, input int pulse, input int bp);
        return pixels + fp + pulse + bp;
    endfunction

    // Width of the pixel counters, big enough for either axis.
    function automatic int cnt_width(input int h_frame, input int v_frame);
        return (h_frame > v_frame) ? $clog2(h_frame) : $clog2(v_frame);
    endfunction

endpackage

// File: rtl/vga_square_gen_if.sv
// Link between the raster timing block and the square renderer.
// Signal protocol: h_cnt, v_cnt and frame_end are live (same cycle as the
// counters); disp_en, hs, vs, frame_start, pix_x and pix_y are registered and
// describe the counter state of the previous cycle. There is no back-pressure:
// the timing block free-runs and the consumer must take every cycle.
interface vga_square_gen_if #(
    parameter int CW = 10
);
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          frame_end;
    logic          disp_en;
    logic          hs;
    logic          vs;
    logic          frame_start;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;

    modport master (
        output h_cnt, v_cnt, frame_end, disp_en, hs, vs, frame_start, pix_x, pix_y
    );

    modport slave (
        input h_cnt, v_cnt, frame_end, disp_en, hs, vs, frame_start, pix_x, pix_y
    );
endinterface

// File: rtl/vga_timing.sv
// Raster timing: free-running h/v counters plus registered sync, visible-area
// flag, frame-start pulse and pixel coordinates (one clock behind the counters).
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_PIXELS = DEF_H_PIXELS,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_PULSE  = DEF_H_PULSE,
    parameter int   H_BP     = DEF_H_BP,
    parameter logic H_POL    = 1'b0,
    parameter int   V_PIXELS = DEF_V_PIXELS,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_PULSE  = DEF_V_PULSE,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic V_POL    = 1'b1,
    parameter int   CW       = cnt_width(frame_len(H_PIXELS, H_FP, H_PULSE, H_BP),
                                         frame_len(V_PIXELS, V_FP, V_PULSE, V_BP))
) (
    input  logic         clk,
    input  logic         reset_n,
    vga_square_gen_if.master tif
);

    localparam int H_FRAME = frame_len(H_PIXELS, H_FP, H_PULSE, H_BP);
    localparam int V_FRAME = frame_len(V_PIXELS, V_FP, V_PULSE, V_BP);
    localparam logic [CW-1:0] H_LAST = CW'(H_FRAME - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_FRAME - 1);

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_last, v_last, h_vis, v_vis, h_sync, v_sync;
    logic          disp_en_q, hs_q, vs_q, fs_q;
    logic [CW-1:0] pix_x_q, pix_y_q;

    // Region decode of the live counters: visible, front porch, sync, back porch.
    always_comb begin
        h_last = (h_cnt == H_LAST);
        v_last = (v_cnt == V_LAST);
        h_vis  = (32'(h_cnt) < H_PIXELS);
        v_vis  = (32'(v_cnt) < V_PIXELS);
        h_sync = (32'(h_cnt) >= H_PIXELS + H_FP) && (32'(h_cnt) < H_PIXELS + H_FP + H_PULSE);
        v_sync = (32'(v_cnt) >= V_PIXELS + V_FP) && (32'(v_cnt) < V_PIXELS + V_FP + V_PULSE);
    end

    // Horizontal counter wraps every line; vertical advances on each horizontal wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + CW'(1);
        end else begin
            h_cnt <= h_cnt + CW'(1);
        end
    end

    // Registered outputs present the counter state of the previous cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_en_q <= 1'b0;
            hs_q      <= ~H_POL;
            vs_q      <= ~V_POL;
            fs_q      <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
        end else begin
            disp_en_q <= h_vis && v_vis;
            hs_q      <= h_sync ? H_POL : ~H_POL;
            vs_q      <= v_sync ? V_POL : ~V_POL;
            fs_q      <= h_last && v_last;
            pix_x_q   <= h_cnt;
            pix_y_q   <= v_cnt;
        end
    end

    assign tif.h_cnt       = h_cnt;
    assign tif.v_cnt       = v_cnt;
    assign tif.frame_end   = h_last && v_last;
    assign tif.disp_en     = disp_en_q;
    assign tif.hs          = hs_q;
    assign tif.vs          = vs_q;
    assign tif.frame_start = fs_q;
    assign tif.pix_x       = pix_x_q;
    assign tif.pix_y       = pix_y_q;

endmodule

// File: rtl/vga_square_gen.sv
// VGA test pattern: a square of side 2*SQ_SIZE moved by held direction keys,
// one SQ_STEP per frame. Build option VGA_SQUARE_WRAP_EN: when defined, a step
// past an edge wraps to the opposite limit; otherwise the position saturates.
module vga_square_gen
    import vga_pkg::*;
#(
    parameter int   H_PIXELS = DEF_H_PIXELS,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_PULSE  = DEF_H_PULSE,
    parameter int   H_BP     = DEF_H_BP,
    parameter logic H_POL    = 1'b0,
    parameter int   V_PIXELS = DEF_V_PIXELS,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_PULSE  = DEF_V_PULSE,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic V_POL    = 1'b1,
    parameter int   COLOR_W  = DEF_COLOR_W,
    parameter int   SQ_SIZE  = 10,
    parameter int   SQ_STEP  = 2,
    parameter int   INIT_X   = 320,
    parameter int   INIT_Y   = 240,
    parameter logic [3*COLOR_W-1:0] FG_RGB = '1,
    parameter logic [3*COLOR_W-1:0] BG_RGB = '0,
    localparam int  CW = cnt_width(frame_len(H_PIXELS, H_FP, H_PULSE, H_BP),
                                   frame_len(V_PIXELS, V_FP, V_PULSE, V_BP))
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mv_up,
    input  logic               mv_down,
    input  logic               mv_left,
    input  logic               mv_right,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               disp_en,
    output logic               frame_start,
    output logic [CW-1:0]      pix_x,
    output logic [CW-1:0]      pix_y
);

    // Signed, two bits wider than the counters so pos - SQ_SIZE never wraps.
    localparam int PW = CW + 2;
    typedef logic signed [PW-1:0] spos_t;

    localparam spos_t SIZE  = spos_t'(SQ_SIZE);
    localparam spos_t STEP  = spos_t'(SQ_STEP);
    localparam spos_t X_MIN = spos_t'(SQ_SIZE);
    localparam spos_t X_MAX = spos_t'(H_PIXELS - SQ_SIZE);
    localparam spos_t Y_MIN = spos_t'(SQ_SIZE);
    localparam spos_t Y_MAX = spos_t'(V_PIXELS - SQ_SIZE);
    localparam spos_t H_VIS = spos_t'(H_PIXELS);
    localparam spos_t V_VIS = spos_t'(V_PIXELS);

    vga_square_gen_if #(.CW(CW)) t_if ();

    vga_timing #(
        .H_PIXELS(H_PIXELS), .H_FP(H_FP), .H_PULSE(H_PULSE), .H_BP(H_BP), .H_POL(H_POL),
        .V_PIXELS(V_PIXELS), .V_FP(V_FP), .V_PULSE(V_PULSE), .V_BP(V_BP), .V_POL(V_POL),
        .CW(CW)
    ) u_timing (
        .clk     (clk),
        .reset_n (reset_n),
        .tif     (t_if.master)
    );

    // Key levels, ordered {up, down, left, right}.
    logic [3:0] key_meta, key_sync;
    spos_t      pos_x, pos_y, cx, cy;
    logic       vis, hit;
    logic [3*COLOR_W-1:0] rgb_q;

    // One axis step: opposing keys cancel, then wrap or saturate at the limits.
    function automatic spos_t step_axis(input spos_t pos, input logic dec, input logic inc,
                                        input spos_t lo, input spos_t hi);
        spos_t nxt;
        nxt = pos;
        if (dec && !inc) nxt = pos - STEP;
        else if (inc && !dec) nxt = pos + STEP;
`ifdef VGA_SQUARE_WRAP_EN
        if (nxt < lo) nxt = hi;
        else if (nxt > hi) nxt = lo;
`else
        if (nxt < lo) nxt = lo;
        else if (nxt > hi) nxt = hi;
`endif
        return nxt;
    endfunction

    // Two-flop synchroniser for the asynchronous key inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            key_meta <= {mv_up, mv_down, mv_left, mv_right};
            key_sync <= key_meta;
        end
    end

    // Move only on the last counter state of a frame, so a frame never mixes positions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x <= spos_t'(INIT_X);
            pos_y <= spos_t'(INIT_Y);
        end else if (t_if.frame_end) begin
            pos_x <= step_axis(pos_x, key_sync[1], key_sync[0], X_MIN, X_MAX);
            pos_y <= step_axis(pos_y, key_sync[3], key_sync[2], Y_MIN, Y_MAX);
        end
    end

    // Square hit test on the live counters, in signed arithmetic.
    always_comb begin
        cx  = $signed({2'b00, t_if.h_cnt});
        cy  = $signed({2'b00, t_if.v_cnt});
        vis = (cx < H_VIS) && (cy < V_VIS);
        hit = (cx >= pos_x - SIZE) && (cx < pos_x + SIZE) &&
              (cy >= pos_y - SIZE) && (cy < pos_y + SIZE);
    end

    // Colour register, aligned with the timing block's registered outputs; black in blanking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rgb_q <= '0;
        else if (!vis) rgb_q <= '0;
        else if (hit) rgb_q <= FG_RGB;
        else rgb_q <= BG_RGB;
    end

    assign {vga_r, vga_g, vga_b} = rgb_q;
    assign vga_hs      = t_if.hs;
    assign vga_vs      = t_if.vs;
    assign disp_en     = t_if.disp_en;
    assign frame_start = t_if.frame_start;
    assign pix_x       = t_if.pix_x;
    assign pix_y       = t_if.pix_y;

endmodule
